// File: rtl/lcd_pkg.sv
// Shared definitions for the text-LCD path: command encodings, geometry,
// fill character and DDRAM line base addresses used by the driver.
package lcd_pkg;

   localparam int LCD_COLS  = 16;
   localparam int LCD_LINES = 2;
   localparam int COL_W     = $clog2(LCD_COLS);
   localparam int LINE_W    = $clog2(LCD_LINES);
   localparam int ADDR_W    = LINE_W + COL_W;

   localparam logic [7:0] FILL_CHAR   = 8'h20;
   localparam logic [7:0] DDRAM_LINE0 = 8'h80;
   localparam logic [7:0] DDRAM_LINE1 = 8'hC0;

   typedef enum logic [1:0] {
      CMD_PUTC    = 2'b00,
      CMD_SETPOS  = 2'b01,
      CMD_CLEAR   = 2'b10,
      CMD_NEWLINE = 2'b11
   } lcd_cmd_e;

   typedef enum logic {
      ST_CLR  = 1'b0,
      ST_IDLE = 1'b1
   } buf_state_e;

   // Start of the other line: invert the line field, zero the column.
   function automatic logic [ADDR_W-1:0] next_line_pos(input logic [ADDR_W-1:0] pos);
      return {~pos[ADDR_W-1:COL_W], {COL_W{1'b0}}};
   endfunction

endpackage

// File: rtl/lcd_cursor_ctr.sv
// Write cursor for the character buffer: advance after PUTC, load on SETPOS,
// jump to the other line on NEWLINE, held at home while the buffer clears.
module lcd_cursor_ctr
   import lcd_pkg::*;
#(
   parameter int AW = ADDR_W
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_zero,
   input  logic          i_advance,
   input  logic          i_setpos,
   input  logic          i_newline,
   input  logic [AW-1:0] i_pos,
   output logic [AW-1:0] o_cursor
);

   logic [AW-1:0] r_cursor;
   logic [AW-1:0] w_cursor_nxt;

   // Next cursor value; the increment wraps modulo the cell count.
   always_comb begin
      w_cursor_nxt = r_cursor;
      if (i_zero) begin
         w_cursor_nxt = {AW{1'b0}};
      end else if (i_advance) begin
         w_cursor_nxt = r_cursor + {{(AW-1){1'b0}}, 1'b1};
      end else if (i_setpos) begin
         w_cursor_nxt = i_pos;
      end else if (i_newline) begin
         w_cursor_nxt = next_line_pos(r_cursor);
      end else begin
         w_cursor_nxt = r_cursor;
      end
   end

   // Cursor register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cursor <= {AW{1'b0}};
      end else begin
         r_cursor <= w_cursor_nxt;
      end
   end

   assign o_cursor = r_cursor;

endmodule

// File: rtl/lcd_char_buffer.sv
// 2x16 character frame buffer between application writes and the LCD driver,
// with a self-clearing FSM, registered read port and frame dirty handshake.
module lcd_char_buffer
   import lcd_pkg::*;
#(
   parameter int         COLS      = LCD_COLS,
   parameter int         LINES     = LCD_LINES,
   parameter logic [7:0] FILL_CHAR = lcd_pkg::FILL_CHAR,
   parameter int         AW        = $clog2(LINES) + $clog2(COLS)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [1:0]    wr_cmd,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_char,
   output logic          frame_req,
   input  logic          frame_ack,
   output logic [AW-1:0] cursor
);

   localparam int            DEPTH     = COLS * LINES;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   buf_state_e    r_state;
   logic [AW-1:0] r_clr_addr;
   logic          r_wr_ready;
   logic          r_frame_req;
   logic [7:0]    r_rd_char;
   logic [7:0]    r_mem [DEPTH];

   lcd_cmd_e      w_cmd;
   logic          w_accept, w_putc, w_setpos, w_clear, w_newline;
   logic          w_clr_last, w_modify;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_addr;
   logic [7:0]    w_mem_data;
   logic [AW-1:0] w_cursor;
   logic          w_unused;

   assign w_cmd      = lcd_cmd_e'(wr_cmd);
   assign w_accept   = wr_valid & r_wr_ready;
   assign w_putc     = w_accept & (w_cmd == CMD_PUTC);
   assign w_setpos   = w_accept & (w_cmd == CMD_SETPOS);
   assign w_clear    = w_accept & (w_cmd == CMD_CLEAR);
   assign w_newline  = w_accept & (w_cmd == CMD_NEWLINE);
   assign w_clr_last = (r_state == ST_CLR) & (r_clr_addr == LAST_ADDR);
   // Completing a clear counts as a modification just like a PUTC.
   assign w_modify   = w_putc | w_clr_last;
   assign w_unused   = &{1'b0, wr_data[7:AW]};

   // Storage write port: the clear sweep owns it while clearing.
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_addr = w_cursor;
      w_mem_data = wr_data;
      case (r_state)
         ST_CLR: begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_addr;
            w_mem_data = FILL_CHAR;
         end
         ST_IDLE: begin
            w_mem_we   = w_putc;
            w_mem_addr = w_cursor;
            w_mem_data = wr_data;
         end
         default: begin
            w_mem_we   = 1'b0;
            w_mem_addr = w_cursor;
            w_mem_data = wr_data;
         end
      endcase
   end

   // Control FSM with registered wr_ready and frame dirty flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_CLR;
         r_clr_addr  <= {AW{1'b0}};
         r_wr_ready  <= 1'b0;
         r_frame_req <= 1'b0;
      end else begin
         case (r_state)
            ST_CLR: begin
               r_clr_addr <= r_clr_addr + {{(AW-1){1'b0}}, 1'b1};
               if (w_clr_last) begin
                  r_state    <= ST_IDLE;
                  r_wr_ready <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (w_clear) begin
                  r_state    <= ST_CLR;
                  r_clr_addr <= {AW{1'b0}};
                  r_wr_ready <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_CLR;
               r_clr_addr <= {AW{1'b0}};
               r_wr_ready <= 1'b0;
            end
         endcase
         if (w_modify) begin
            r_frame_req <= 1'b1;
         end else if (frame_ack) begin
            r_frame_req <= 1'b0;
         end
      end
   end

   // Cell array; contents are rebuilt by the clear sweep after every reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Registered read, sampled before any same-edge write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_char <= FILL_CHAR;
      end else begin
         r_rd_char <= r_mem[rd_addr];
      end
   end

   lcd_cursor_ctr #(
      .AW (AW)
   ) u_cursor (
      .clk       (clk),
      .rst       (rst),
      .i_zero    (r_state == ST_CLR),
      .i_advance (w_putc),
      .i_setpos  (w_setpos),
      .i_newline (w_newline),
      .i_pos     (wr_data[AW-1:0]),
      .o_cursor  (w_cursor)
   );

   assign wr_ready  = r_wr_ready;
   assign frame_req = r_frame_req;
   assign rd_char   = r_rd_char;
   assign cursor    = w_cursor;

endmodule

// File: tb/tb_lcd_char_buffer.sv
// Directed bench for lcd_char_buffer: reference cell array and cursor model,
// read expectations queued when the address is driven and checked a cycle later.
module tb_lcd_char_buffer;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_cmd;
   logic [7:0] wr_data;
   logic [4:0] rd_addr;
   logic [7:0] rd_char;
   logic       frame_req;
   logic       frame_ack;
   logic [4:0] cursor;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] model_mem [32];
   logic [4:0] model_cur;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   lcd_char_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_cmd    (wr_cmd),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_char   (rd_char),
      .frame_req (frame_req),
      .frame_ack (frame_ack),
      .cursor    (cursor)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_fill();
      for (int i = 0; i < 32; i++) model_mem[i] = 8'h20;
      model_cur = 5'd0;
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_cmd   = cmd;
      wr_data  = d;
      case (cmd)
         CMD_PUTC: begin
            model_mem[model_cur] = d;
            model_cur = model_cur + 5'd1;
         end
         CMD_SETPOS:  model_cur = d[4:0];
         CMD_NEWLINE: model_cur = {~model_cur[4], 4'b0000};
         default:     model_cur = model_cur;
      endcase
      step();
      wr_valid = 1'b0;
   endtask

   task automatic rd_check(input logic [4:0] a, input string tag);
      logic [7:0] e;
      rd_addr = a;
      exp_q.push_back(model_mem[a]);
      step();
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, a), rd_char, e);
   endtask

   task automatic clear_wait(input string tag);
      int busy;
      busy = 0;
      for (int i = 0; i < 31; i++) begin
         step();
         if (wr_ready !== 1'b0) busy++;
      end
      chk({tag, "_busy31"}, busy, 0);
      step();
      chk({tag, "_ready"}, wr_ready, 1'b1);
      chk({tag, "_frame_req"}, frame_req, 1'b1);
      chk({tag, "_cursor"}, cursor, 5'd0);
   endtask

   initial begin
      rst       = 1'b0;
      wr_valid  = 1'b0;
      wr_cmd    = 2'b00;
      wr_data   = 8'h00;
      rd_addr   = 5'd0;
      frame_ack = 1'b0;
      model_fill();

      #12;
      chk("rst_cursor", cursor, 5'd0);
      chk("rst_rd_char", rd_char, 8'h20);
      chk("rst_frame_req", frame_req, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);

      @(negedge clk);
      rst = 1'b1;
      clear_wait("init");
      for (int a = 0; a < 32; a++) rd_check(5'(a), "init_cell");

      issue(CMD_PUTC, 8'h48);
      issue(CMD_PUTC, 8'h45);
      issue(CMD_PUTC, 8'h4C);
      issue(CMD_PUTC, 8'h4C);
      issue(CMD_PUTC, 8'h4F);
      chk("hello_cursor", cursor, model_cur);
      for (int a = 0; a < 6; a++) rd_check(5'(a), "hello_cell");

      issue(CMD_SETPOS, 8'h0F);
      chk("setpos_0f", cursor, model_cur);
      issue(CMD_PUTC, 8'h41);
      issue(CMD_PUTC, 8'h42);
      chk("wrap_line_cursor", cursor, model_cur);
      rd_check(5'd15, "wrap_cell");
      rd_check(5'd16, "wrap_cell");
      issue(CMD_SETPOS, 8'h1F);
      issue(CMD_PUTC, 8'h5A);
      chk("wrap_end_cursor", cursor, model_cur);
      rd_check(5'd31, "wrap_cell");
      issue(CMD_SETPOS, 8'hE3);
      chk("setpos_hibits", cursor, model_cur);
      issue(CMD_NEWLINE, 8'h00);
      chk("newline_0to1", cursor, model_cur);
      issue(CMD_NEWLINE, 8'h00);
      chk("newline_1to0", cursor, model_cur);

      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
      chk("ack_clears", frame_req, 1'b0);
      frame_ack = 1'b1;
      issue(CMD_PUTC, 8'h78);
      frame_ack = 1'b0;
      chk("ack_with_putc", frame_req, 1'b1);
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
      chk("ack_again", frame_req, 1'b0);
      issue(CMD_SETPOS, 8'h03);
      chk("setpos_not_dirty", frame_req, 1'b0);
      issue(CMD_NEWLINE, 8'h00);
      chk("newline_not_dirty", frame_req, 1'b0);
      issue(CMD_SETPOS, 8'h03);

      rd_addr = 5'd3;
      exp_q.push_back(model_mem[3]);
      issue(CMD_PUTC, 8'h51);
      chk("collide_old", rd_char, exp_q.pop_front());
      rd_check(5'd3, "collide_new");
      chk("collide_dirty", frame_req, 1'b1);

      issue(CMD_CLEAR, 8'h00);
      chk("clear_busy", wr_ready, 1'b0);
      for (int i = 0; i < 9; i++) step();
      #2 rst = 1'b0;
      #1;
      chk("midclr_rst_ready", wr_ready, 1'b0);
      chk("midclr_rst_frame_req", frame_req, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      model_fill();
      clear_wait("reclr");
      for (int a = 0; a < 32; a++) rd_check(5'(a), "reclr_cell");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
